// File: rtl/result_merger_sa.sv
// result_merger_sa
//   Merges the two result ports of the classification pipeline into one
//   in-order stream with a valid/ready handshake. The pipeline cannot be
//   stalled, so its results are absorbed in a small show-ahead FIFO. Any
//   result that finds no free slot is dropped and counted.
//
// Ports
//   clk, RSTn                     clock, async active-low reset
//   rule_id1/2, data_valid_in1/2,
//   action_valid1/2               dual-port input results (port 1 is older)
//   out_ready                     consumer takes the head entry this cycle
//   overflow_clr                  clears overflow and drop_cnt
//   rule_id_out, action_valid_out head entry (show-ahead)
//   data_valid_out                head entry present
//   fifo_count                    occupied entries, 0..FIFO_DEPTH
//   overflow, drop_cnt            sticky drop flag, saturating drop count

// One FIFO slot: holds {action_valid, rule_id}, cleared on reset.
module result_merger_sa_cell #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         RSTn,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)   q <= '0;
    else if (we) q <= d;
  end
endmodule

module result_merger_sa #(
  parameter int RULE_ID    = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic [RULE_ID-1:0]    rule_id1,
  input  logic [RULE_ID-1:0]    rule_id2,
  input  logic                  data_valid_in1,
  input  logic                  data_valid_in2,
  input  logic                  action_valid1,
  input  logic                  action_valid2,
  input  logic                  out_ready,
  input  logic                  overflow_clr,
  output logic [RULE_ID-1:0]    rule_id_out,
  output logic                  action_valid_out,
  output logic                  data_valid_out,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic [DROP_WIDTH-1:0] drop_cnt
);
  localparam int EW = RULE_ID + 1;   // entry width: {action_valid, rule_id}

  logic [ADDR_WIDTH-1:0]               wr_ptr, rd_ptr, wr_ptr2;
  logic [ADDR_WIDTH:0]                 count;
  logic [FIFO_DEPTH-1:0][EW-1:0]       mem_q;
  logic [EW-1:0]                       ent1, ent2;
  logic                                pop, acc1, acc2;
  logic [ADDR_WIDTH+1:0]               free;
  logic [1:0]                          pushes, drops;
  logic [DROP_WIDTH:0]                 drop_sum;

  assign ent1 = {action_valid1, rule_id1};
  assign ent2 = {action_valid2, rule_id2};

  assign data_valid_out = (count != '0);
  assign pop            = data_valid_out & out_ready;

  // A same-cycle pop frees a slot that this cycle's push may reuse.
  assign free = (ADDR_WIDTH+2)'(FIFO_DEPTH) - {1'b0, count}
              + {{(ADDR_WIDTH+1){1'b0}}, pop};

  // Port 1 is older, so it claims the first free slot.
  assign acc1 = data_valid_in1 & (free != '0);
  assign acc2 = data_valid_in2 &
                (data_valid_in1 ? (free >= (ADDR_WIDTH+2)'(2)) : (free != '0));

  assign pushes = {1'b0, acc1} + {1'b0, acc2};
  assign drops  = {1'b0, data_valid_in1 & ~acc1} + {1'b0, data_valid_in2 & ~acc2};

  // Port 2 lands right after port 1 when both are accepted.
  assign wr_ptr2 = wr_ptr + ADDR_WIDTH'(acc1);

  genvar i;
  generate
    for (i = 0; i < FIFO_DEPTH; i++) begin : g_cell
      logic          hit1, hit2;
      logic [EW-1:0] d;
      assign hit1 = acc1 & (wr_ptr  == ADDR_WIDTH'(i));
      assign hit2 = acc2 & (wr_ptr2 == ADDR_WIDTH'(i));
      assign d    = hit1 ? ent1 : ent2;
      result_merger_sa_cell #(.W(EW)) u_cell (
        .clk  (clk),
        .RSTn (RSTn),
        .we   (hit1 | hit2),
        .d    (d),
        .q    (mem_q[i])
      );
    end
  endgenerate

  assign {action_valid_out, rule_id_out} = mem_q[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(pushes);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(pop);
      count  <= count + (ADDR_WIDTH+1)'(pushes) - (ADDR_WIDTH+1)'(pop);
    end
  end

  // A clear in the same cycle as a drop restarts the count from this drop.
  assign drop_sum = {1'b0, (overflow_clr ? {DROP_WIDTH{1'b0}} : drop_cnt)}
                  + (DROP_WIDTH+1)'(drops);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drops != 2'd0) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sum[DROP_WIDTH] ? {DROP_WIDTH{1'b1}} : drop_sum[DROP_WIDTH-1:0];
    end else if (overflow_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_result_merger_sa.sv
// Testbench for result_merger_sa: a table of per-cycle vectors with
// hand-computed expected state after each clock edge, followed by
// hand-written sequences for drain order, wrap-around and mid-run reset.
module tb_result_merger_sa;
  logic        clk = 1'b0;
  logic        RSTn;
  logic [13:0] rule_id1, rule_id2, rule_id_out;
  logic        data_valid_in1, data_valid_in2, action_valid1, action_valid2;
  logic        out_ready, overflow_clr;
  logic        action_valid_out, data_valid_out, overflow;
  logic [4:0]  fifo_count;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  result_merger_sa dut (
    .clk(clk), .RSTn(RSTn),
    .rule_id1(rule_id1), .rule_id2(rule_id2),
    .data_valid_in1(data_valid_in1), .data_valid_in2(data_valid_in2),
    .action_valid1(action_valid1), .action_valid2(action_valid2),
    .out_ready(out_ready), .overflow_clr(overflow_clr),
    .rule_id_out(rule_id_out), .action_valid_out(action_valid_out),
    .data_valid_out(data_valid_out), .fifo_count(fifo_count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v1; logic [13:0] id1; logic a1;
    logic v2; logic [13:0] id2; logic a2;
    logic rdy; logic clr;
    logic e_dv; logic [13:0] e_id; logic e_act;
    int   e_cnt; logic e_ovf; int e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v1, int id1, logic a1, logic v2, int id2, logic a2,
                              logic rdy, logic clr, logic e_dv, int e_id, logic e_act,
                              int e_cnt, logic e_ovf, int e_drop);
    vec_t v;
    v.v1 = v1; v.id1 = 14'(id1); v.a1 = a1;
    v.v2 = v2; v.id2 = 14'(id2); v.a2 = a2;
    v.rdy = rdy; v.clr = clr;
    v.e_dv = e_dv; v.e_id = 14'(e_id); v.e_act = e_act;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v1, input int id1, input logic a1,
                       input logic v2, input int id2, input logic a2,
                       input logic rdy, input logic clr);
    data_valid_in1 = v1; rule_id1 = 14'(id1); action_valid1 = a1;
    data_valid_in2 = v2; rule_id2 = 14'(id2); action_valid2 = a2;
    out_ready = rdy; overflow_clr = clr;
  endtask

  // Advance one clock and sample #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input int id, input logic act, input int cnt);
    chk({name, ".dv"}, int'(data_valid_out), 1);
    chk({name, ".id"}, int'(rule_id_out), id);
    chk({name, ".act"}, int'(action_valid_out), int'(act));
    chk({name, ".cnt"}, int'(fifo_count), cnt);
  endtask

  initial begin
    // ---- vector table ----
    // single result: appears next cycle, leaves the cycle after
    tbl.push_back(mk(1,'h005,1, 0,0,0, 1,0,  1,'h005,1, 1,0,0));
    tbl.push_back(mk(0,0,0,     0,0,0, 1,0,  0,0,0,      0,0,0));
    // dual same-cycle, port 1 first
    tbl.push_back(mk(1,'h010,0, 1,'h020,1, 1,0, 1,'h010,0, 2,0,0));
    tbl.push_back(mk(0,0,0,     0,0,0,     1,0, 1,'h020,1, 1,0,0));
    tbl.push_back(mk(0,0,0,     0,0,0,     1,0, 0,0,0,      0,0,0));
    // fill with 8 dual cycles, no pop: head stays 0x100
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1,'h100+2*k,1, 1,'h101+2*k,0, 0,0, 1,'h100,1, 2*(k+1),0,0));
    // one more dual cycle at full: both dropped
    tbl.push_back(mk(1,'h200,1, 1,'h201,1, 0,0, 1,'h100,1, 16,1,2));
    // full with pop: port 1 accepted, port 2 dropped
    tbl.push_back(mk(1,'h300,1, 1,'h301,0, 1,0, 1,'h101,0, 16,1,3));
    // clear
    tbl.push_back(mk(0,0,0, 0,0,0, 0,1, 1,'h101,0, 16,0,0));
    // clear coincident with a drop: drop wins
    tbl.push_back(mk(1,'h3AA,1, 0,0,0, 0,1, 1,'h101,0, 16,1,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,1, 1,'h101,0, 16,0,0));

    // ---- reset ----
    drive(0,0,0, 0,0,0, 0,0);
    RSTn = 1'b0;
    #12;
    chk("rst.dv",   int'(data_valid_out), 0);
    chk("rst.id",   int'(rule_id_out), 0);
    chk("rst.act",  int'(action_valid_out), 0);
    chk("rst.cnt",  int'(fifo_count), 0);
    chk("rst.ovf",  int'(overflow), 0);
    chk("rst.drop", int'(drop_cnt), 0);
    @(negedge clk);
    RSTn = 1'b1;
    @(posedge clk);
    #1;

    // ---- apply table ----
    foreach (tbl[n]) begin
      drive(tbl[n].v1, int'(tbl[n].id1), tbl[n].a1, tbl[n].v2, int'(tbl[n].id2),
            tbl[n].a2, tbl[n].rdy, tbl[n].clr);
      tick();
      chk($sformatf("vec%0d.dv", n), int'(data_valid_out), int'(tbl[n].e_dv));
      if (tbl[n].e_dv) begin
        chk($sformatf("vec%0d.id", n), int'(rule_id_out), int'(tbl[n].e_id));
        chk($sformatf("vec%0d.act", n), int'(action_valid_out), int'(tbl[n].e_act));
      end
      chk($sformatf("vec%0d.cnt", n), int'(fifo_count), tbl[n].e_cnt);
      chk($sformatf("vec%0d.ovf", n), int'(overflow), int'(tbl[n].e_ovf));
      chk($sformatf("vec%0d.drop", n), int'(drop_cnt), tbl[n].e_drop);
    end

    // ---- drain: 0x101..0x10F then 0x300, in order ----
    drive(0,0,0, 0,0,0, 1,0);
    for (int j = 0; j < 16; j++) begin
      int exp_id;
      logic exp_act;
      exp_id  = (j < 15) ? ('h101 + j) : 'h300;
      exp_act = (j < 15) ? ~exp_id[0] : 1'b1;
      chk_head($sformatf("drain%0d", j), exp_id, exp_act, 16 - j);
      tick();
    end
    chk("drain.empty", int'(data_valid_out), 0);
    chk("drain.cnt",   int'(fifo_count), 0);

    // ---- push+pop at count 1 ----
    drive(1,'h033,0, 0,0,0, 0,0);
    tick();
    chk_head("pp.first", 'h033, 0, 1);
    drive(0,0,0, 1,'h044,1, 1,0);
    tick();
    chk_head("pp.second", 'h044, 1, 1);
    drive(0,0,0, 0,0,0, 1,0);
    tick();
    chk("pp.empty", int'(fifo_count), 0);

    // ---- wrap-around: 40 singles, alternating ports, out_ready high ----
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) drive(1,k,k%3==0, 0,0,0, 1,0);
      else            drive(0,0,0, 1,k,k%3==0, 1,0);
      tick();
      chk_head($sformatf("wrap%0d", k), k, k%3==0, 1);
    end
    drive(0,0,0, 0,0,0, 1,0);
    tick();
    chk("wrap.cnt",  int'(fifo_count), 0);
    chk("wrap.drop", int'(drop_cnt), 0);
    chk("wrap.ovf",  int'(overflow), 0);

    // ---- reset mid-operation with count 5 ----
    for (int k = 0; k < 5; k++) begin
      drive(1,'h070+k,1, 0,0,0, 0,0);
      tick();
    end
    drive(1,'h200,1, 1,'h201,1, 0,0);   // pending inputs get discarded
    chk("mid.cnt5", int'(fifo_count), 5);
    @(negedge clk);
    RSTn = 1'b0;
    #1;
    chk("mid.dv",  int'(data_valid_out), 0);
    chk("mid.id",  int'(rule_id_out), 0);
    chk("mid.act", int'(action_valid_out), 0);
    chk("mid.cnt", int'(fifo_count), 0);
    @(posedge clk);
    #1;
    chk("mid.hold", int'(fifo_count), 0);
    @(negedge clk);
    RSTn = 1'b1;
    drive(1,'h055,0, 0,0,0, 0,0);
    tick();
    chk_head("mid.post", 'h055, 0, 1);
    drive(0,0,0, 0,0,0, 1,0);
    tick();
    chk("mid.drain.dv", int'(data_valid_out), 0);
    chk("mid.drain.ovf", int'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
